cpu_dram_port: RTL and testbench

CPU_DRAM_PORT -- requirements
Module: cpu_dram_port

---
 rtl/cpu_dram_port_if.sv | 45 ++++
 rtl/cpu_dram_port.sv | 136 +++++++++++++
 tb/tb_cpu_dram_port.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_dram_port_if.sv
// Bus bundle between the CPU/video requesters, the phase generator and the
// DRAM controller. The slave view belongs to cpu_dram_port itself.
interface cpu_dram_port_if;
  logic        c0;
  logic        c1;
  logic        c2;
  logic        c3;
  logic        cpu_req;
  logic        cpu_rnw;
  logic [20:0] cpu_addr;
  logic        cpu_wrbsel;
  logic [7:0]  cpu_wrdata;
  logic        vid_req;
  logic [20:0] vid_addr;
  logic        cpu_next;
  logic        cpu_strobe;
  logic        cpu_latch;
  logic [15:0] cpu_rddata;
  logic        vid_strobe;
  logic        dram_req;
  logic        dram_rnw;
  logic [20:0] dram_addr;
  logic [1:0]  dram_bsel;
  logic [15:0] dram_wrdata;
  logic        dram_rdvalid;
  logic [15:0] dram_rdata;

  modport slave (
    input  c0, c1, c2, c3,
    input  cpu_req, cpu_rnw, cpu_addr, cpu_wrbsel, cpu_wrdata,
    input  vid_req, vid_addr,
    output cpu_next, cpu_strobe, cpu_latch, cpu_rddata, vid_strobe,
    output dram_req, dram_rnw, dram_addr, dram_bsel, dram_wrdata,
    input  dram_rdvalid, dram_rdata
  );

  modport master (
    output c0, c1, c2, c3,
    output cpu_req, cpu_rnw, cpu_addr, cpu_wrbsel, cpu_wrdata,
    output vid_req, vid_addr,
    input  cpu_next, cpu_strobe, cpu_latch, cpu_rddata, vid_strobe,
    input  dram_req, dram_rnw, dram_addr, dram_bsel, dram_wrdata,
    output dram_rdvalid, dram_rdata
  );
endinterface

// File: rtl/cpu_dram_port.sv
// DRAM port arbiter shared by CPU and video. One DRAM cycle per c0..c3
// rotation; ownership of the next cycle is decided at c3. Video has priority
// until the CPU has lost STARVE_MAX arbitrations in a row. A CPU read whose
// data is late parks the port in WAIT until the data shows up.
module cpu_dram_port #(
  parameter int unsigned STARVE_MAX = 3
) (
  input logic           clk,
  input logic           rst,
  cpu_dram_port_if.slave bus
);

  localparam logic [1:0] SMAX = STARVE_MAX[1:0];

  typedef enum logic [1:0] {IDLE, CPU, VID, WAIT} owner_t;

  owner_t      state, state_nxt;
  logic [1:0]  starve_cnt, starve_nxt;
  logic        grant_cpu, grant_vid;
  logic        arb_phase;
  logic        cpu_next_w;
  logic        cyc_active;
  logic        cpu_rd_cycle;
  logic        got_rd;
  logic        wait_strobe;
  logic        latch_q;
  logic        cpu_strobe_w;
  logic        dram_req_q;
  logic        dram_rnw_q;
  logic [20:0] dram_addr_q;
  logic [1:0]  dram_bsel_q;
  logic [15:0] dram_wrdata_q;
  logic [15:0] rddata_q;

  // Arbitrate only on a clean c3; an overlapping (non one-hot) strobe is ignored.
  assign arb_phase    = bus.c3 & ~(bus.c0 | bus.c1 | bus.c2);
  assign cpu_next_w   = (state != WAIT) && (!bus.vid_req || (starve_cnt >= SMAX));
  assign cyc_active   = (state == CPU) || (state == VID);
  assign cpu_rd_cycle = (state == CPU) && dram_rnw_q;

  // Next owner, grant decode and starvation counter update
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    grant_cpu  = 1'b0;
    grant_vid  = 1'b0;
    if (state == WAIT) begin
      if (bus.dram_rdvalid) state_nxt = IDLE;
    end else if (arb_phase) begin
      if (cpu_rd_cycle && !got_rd && !bus.dram_rdvalid) begin
        state_nxt = WAIT;
      end else if (bus.vid_req && (starve_cnt < SMAX)) begin
        grant_vid = 1'b1;
        state_nxt = VID;
      end else if (bus.cpu_req && cpu_next_w) begin
        grant_cpu = 1'b1;
        state_nxt = CPU;
      end else if (bus.vid_req) begin
        grant_vid = 1'b1;
        state_nxt = VID;
      end else begin
        state_nxt = IDLE;
      end
    end
    if (arb_phase) begin
      if (grant_cpu || !bus.cpu_req) starve_nxt = '0;
      else if (grant_vid && (starve_cnt < SMAX)) starve_nxt = starve_cnt + 2'd1;
    end
  end

  // Owner state and starvation counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Latch the access parameters at grant; dram_req is high for the c0 that follows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dram_req_q    <= 1'b0;
      dram_rnw_q    <= 1'b1;
      dram_addr_q   <= '0;
      dram_bsel_q   <= '0;
      dram_wrdata_q <= '0;
    end else begin
      dram_req_q <= grant_cpu | grant_vid;
      if (grant_vid) begin
        dram_rnw_q  <= 1'b1;
        dram_addr_q <= bus.vid_addr;
        dram_bsel_q <= '0;
      end else if (grant_cpu) begin
        dram_rnw_q    <= bus.cpu_rnw;
        dram_addr_q   <= bus.cpu_addr;
        dram_bsel_q   <= bus.cpu_rnw ? 2'b00 : (bus.cpu_wrbsel ? 2'b10 : 2'b01);
        dram_wrdata_q <= {bus.cpu_wrdata, bus.cpu_wrdata};
      end
    end
  end

  // Read return tracking: first rdvalid of an owned cycle wins, extras are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      got_rd      <= 1'b0;
      wait_strobe <= 1'b0;
      latch_q     <= 1'b0;
      rddata_q    <= '0;
    end else begin
      if (arb_phase) got_rd <= 1'b0;
      else if (bus.dram_rdvalid && cyc_active) got_rd <= 1'b1;
      wait_strobe <= (state == WAIT) && bus.dram_rdvalid;
      latch_q     <= cpu_strobe_w;
      if (bus.dram_rdvalid && ((cpu_rd_cycle && !got_rd) || (state == WAIT)))
        rddata_q <= bus.dram_rdata;
    end
  end

  // On-time data strobes at c3 (data may land in that same clk); late data strobes one clk after rdvalid
  assign cpu_strobe_w = (cpu_rd_cycle && arb_phase && (got_rd || bus.dram_rdvalid)) || wait_strobe;

  assign bus.cpu_next    = cpu_next_w;
  assign bus.cpu_strobe  = cpu_strobe_w;
  assign bus.cpu_latch   = cpu_strobe_w | latch_q;
  assign bus.cpu_rddata  = rddata_q;
  assign bus.vid_strobe  = (state == VID) && bus.dram_rdvalid && !got_rd;
  assign bus.dram_req    = dram_req_q;
  assign bus.dram_rnw    = dram_rnw_q;
  assign bus.dram_addr   = dram_addr_q;
  assign bus.dram_bsel   = dram_bsel_q;
  assign bus.dram_wrdata = dram_wrdata_q;

endmodule

// File: tb/tb_cpu_dram_port.sv
// Directed bench for cpu_dram_port: read, write, starvation, late data,
// idle and reset-abort scenarios with hand-computed expectations.
module tb_cpu_dram_port;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   ph;

  cpu_dram_port_if bus ();

  cpu_dram_port #(.STARVE_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_phase();
    bus.c0 = (ph == 0);
    bus.c1 = (ph == 1);
    bus.c2 = (ph == 2);
    bus.c3 = (ph == 3);
  endtask

  // Advance one clk; inputs change #1 after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 4;
    set_phase();
  endtask

  task automatic go_to(input int p);
    for (int i = 0; i < 4; i++) begin
      if (ph == p) break;
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ph    = 0;
    set_phase();
    rst              = 1'b1;
    bus.cpu_req      = 1'b0;
    bus.cpu_rnw      = 1'b1;
    bus.cpu_addr     = '0;
    bus.cpu_wrbsel   = 1'b0;
    bus.cpu_wrdata   = '0;
    bus.vid_req      = 1'b0;
    bus.vid_addr     = '0;
    bus.dram_rdvalid = 1'b0;
    bus.dram_rdata   = '0;
    #2;
    check("rst_cpu_next", 32'(bus.cpu_next), 1);
    check("rst_dram_req", 32'(bus.dram_req), 0);
    check("rst_strobe",   32'(bus.cpu_strobe), 0);
    check("rst_latch",    32'(bus.cpu_latch), 0);
    check("rst_vstrobe",  32'(bus.vid_strobe), 0);
    check("rst_rddata",   32'(bus.cpu_rddata), 0);
    check("rst_addr",     32'(bus.dram_addr), 0);
    check("rst_bsel",     32'(bus.dram_bsel), 0);
    check("rst_rnw",      32'(bus.dram_rnw), 1);
    tick();
    tick();
    rst = 1'b0;

    // CPU read, data at c2
    go_to(3);
    bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 21'h012345;
    #1 check("rd_next", 32'(bus.cpu_next), 1);
    tick(); bus.cpu_req = 1'b0;
    #1 check("rd_req", 32'(bus.dram_req), 1);
    check("rd_addr", 32'(bus.dram_addr), 32'h012345);
    check("rd_rnw",  32'(bus.dram_rnw), 1);
    tick();
    #1 check("rd_req_pulse", 32'(bus.dram_req), 0);
    tick(); bus.dram_rdvalid = 1'b1; bus.dram_rdata = 16'hBEEF;
    #1 check("rd_early_strobe", 32'(bus.cpu_strobe), 0);
    check("rd_vstrobe", 32'(bus.vid_strobe), 0);
    tick(); bus.dram_rdvalid = 1'b0;
    #1 check("rd_strobe", 32'(bus.cpu_strobe), 1);
    check("rd_latch1",  32'(bus.cpu_latch), 1);
    check("rd_data",    32'(bus.cpu_rddata), 32'hBEEF);
    tick();
    #1 check("rd_strobe_off", 32'(bus.cpu_strobe), 0);
    check("rd_latch2", 32'(bus.cpu_latch), 1);
    check("rd_idle_req", 32'(bus.dram_req), 0);
    tick();
    #1 check("rd_latch_off", 32'(bus.cpu_latch), 0);

    // CPU write, high byte
    go_to(3);
    bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b0; bus.cpu_wrbsel = 1'b1;
    bus.cpu_wrdata = 8'hA5; bus.cpu_addr = 21'h000777;
    tick(); bus.cpu_req = 1'b0;
    #1 check("wr_req",  32'(bus.dram_req), 1);
    check("wr_bsel",  32'(bus.dram_bsel), 32'h2);
    check("wr_data",  32'(bus.dram_wrdata), 32'hA5A5);
    check("wr_rnw",   32'(bus.dram_rnw), 0);
    check("wr_addr",  32'(bus.dram_addr), 32'h000777);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1 check("wr_no_strobe", 32'(bus.cpu_strobe), 0);
      check("wr_no_latch", 32'(bus.cpu_latch), 0);
    end

    // Starvation: three VID cycles then one CPU cycle
    bus.vid_req = 1'b1; bus.vid_addr = 21'h000200;
    bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 21'h000100;
    for (int i = 0; i < 4; i++) begin
      #1 check("st_next", 32'(bus.cpu_next), (i == 3) ? 1 : 0);
      tick();
      #1 check("st_req", 32'(bus.dram_req), 1);
      check("st_addr", 32'(bus.dram_addr), (i == 3) ? 32'h100 : 32'h200);
      if (i == 3) begin bus.cpu_req = 1'b0; bus.vid_req = 1'b0; end
      tick();
      tick();
      bus.dram_rdvalid = 1'b1;
      bus.dram_rdata   = (i == 3) ? 16'h1234 : 16'h5000;
      #1 check("st_vstrobe", 32'(bus.vid_strobe), (i == 3) ? 0 : 1);
      tick(); bus.dram_rdvalid = 1'b0;
      #1 check("st_strobe", 32'(bus.cpu_strobe), (i == 3) ? 1 : 0);
      check("st_rddata", 32'(bus.cpu_rddata), (i == 3) ? 32'h1234 : 32'hBEEF);
    end

    // Late data: rdvalid 5 clks after dram_req
    tick();
    go_to(3);
    bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 21'h0ABCDE;
    tick(); bus.cpu_req = 1'b0;
    #1 check("late_req", 32'(bus.dram_req), 1);
    tick();
    tick();
    tick();
    #1 check("late_c3_strobe", 32'(bus.cpu_strobe), 0);
    tick(); bus.cpu_req = 1'b1; bus.cpu_addr = 21'h00AAAA;
    #1 check("wait_next", 32'(bus.cpu_next), 0);
    check("wait_no_req", 32'(bus.dram_req), 0);
    tick(); bus.dram_rdvalid = 1'b1; bus.dram_rdata = 16'hCAFE;
    #1 check("wait_rdv_strobe", 32'(bus.cpu_strobe), 0);
    check("wait_next2", 32'(bus.cpu_next), 0);
    tick(); bus.dram_rdvalid = 1'b0;
    #1 check("late_strobe", 32'(bus.cpu_strobe), 1);
    check("late_data",  32'(bus.cpu_rddata), 32'hCAFE);
    check("late_next",  32'(bus.cpu_next), 1);
    tick();
    #1 check("late_strobe_off", 32'(bus.cpu_strobe), 0);
    check("late_latch2", 32'(bus.cpu_latch), 1);
    tick(); bus.cpu_req = 1'b0;
    #1 check("resume_req",  32'(bus.dram_req), 1);
    check("resume_addr", 32'(bus.dram_addr), 32'h00AAAA);
    tick(); bus.dram_rdvalid = 1'b1; bus.dram_rdata = 16'h1111;
    tick(); bus.dram_rdata = 16'h2222;
    tick(); bus.dram_rdvalid = 1'b0;
    #1 check("dup_strobe", 32'(bus.cpu_strobe), 1);
    check("dup_data",   32'(bus.cpu_rddata), 32'h1111);

    // Idle for 8 rotations, with a stray rdvalid
    for (int j = 0; j < 32; j++) begin
      tick();
      bus.dram_rdvalid = (j == 5);
      bus.dram_rdata   = 16'h9999;
      #1 check("idle_req", 32'(bus.dram_req), 0);
      check("idle_next", 32'(bus.cpu_next), 1);
      if (j == 5) begin
        check("idle_vstrobe", 32'(bus.vid_strobe), 0);
        check("idle_strobe",  32'(bus.cpu_strobe), 0);
      end
    end
    bus.dram_rdvalid = 1'b0;
    #1 check("idle_rddata", 32'(bus.cpu_rddata), 32'h1111);

    // Reset at c1 of a CPU read, data arrives afterwards
    go_to(3);
    bus.cpu_req = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 21'h055555;
    tick(); bus.cpu_req = 1'b0;
    #1 check("rr_req",  32'(bus.dram_req), 1);
    check("rr_addr", 32'(bus.dram_addr), 32'h055555);
    tick(); rst = 1'b1;
    #1 check("rr_addr_rst",   32'(bus.dram_addr), 0);
    check("rr_rnw_rst",    32'(bus.dram_rnw), 1);
    check("rr_rddata_rst", 32'(bus.cpu_rddata), 0);
    check("rr_next_rst",   32'(bus.cpu_next), 1);
    tick(); rst = 1'b0; bus.dram_rdvalid = 1'b1; bus.dram_rdata = 16'h7777;
    #1 check("rr_strobe",  32'(bus.cpu_strobe), 0);
    check("rr_vstrobe", 32'(bus.vid_strobe), 0);
    tick(); bus.dram_rdvalid = 1'b0;
    #1 check("rr_c3_strobe", 32'(bus.cpu_strobe), 0);
    check("rr_rddata",    32'(bus.cpu_rddata), 0);
    check("rr_latch",     32'(bus.cpu_latch), 0);
    tick();
    #1 check("rr_req_after", 32'(bus.dram_req), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
